// File: rtl/lc3_control_fsm_pkg.sv
// lc3_control_fsm_pkg: state codes, opcodes, mux/ALU encodings and control word for lc3_control_fsm.
// Pause codes exist only when LC3_PAUSE_EN is defined.
package lc3_control_fsm_pkg;

    localparam logic [4:0] S_HALTED = 5'd0;
    localparam logic [4:0] S_18     = 5'd1;
    localparam logic [4:0] S_33     = 5'd2;
    localparam logic [4:0] S_35     = 5'd3;
    localparam logic [4:0] S_32     = 5'd4;
    localparam logic [4:0] S_01     = 5'd5;
    localparam logic [4:0] S_05     = 5'd6;
    localparam logic [4:0] S_09     = 5'd7;
    localparam logic [4:0] S_00     = 5'd8;
    localparam logic [4:0] S_22     = 5'd9;
    localparam logic [4:0] S_12     = 5'd10;
    localparam logic [4:0] S_04     = 5'd11;
    localparam logic [4:0] S_21     = 5'd12;
    localparam logic [4:0] S_06     = 5'd13;
    localparam logic [4:0] S_25     = 5'd14;
    localparam logic [4:0] S_27     = 5'd15;
    localparam logic [4:0] S_07     = 5'd16;
    localparam logic [4:0] S_23     = 5'd17;
    localparam logic [4:0] S_16     = 5'd18;
`ifdef LC3_PAUSE_EN
    localparam logic [4:0] S_PAUSE1 = 5'd19;
    localparam logic [4:0] S_PAUSE2 = 5'd20;
`endif

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
`ifdef LC3_PAUSE_EN
    localparam logic [3:0] OP_PAUSE = 4'b1101;
`endif

    typedef enum logic [1:0] {PC_INC = 2'b00, PC_BUS = 2'b01, PC_ADDR = 2'b10} pcmux_e;
    typedef enum logic [1:0] {A2_ZERO = 2'b00, A2_OFF6 = 2'b01, A2_OFF9 = 2'b10, A2_OFF11 = 2'b11} addr2mux_e;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASSA = 2'b11} aluk_e;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic mem_oe, mem_we;
    } ctrl_t;

    function automatic logic is_wait_state(input logic [4:0] s);
        return s == S_33 || s == S_25 || s == S_16;
    endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_wait_counter.sv
// mem_wait_counter: fixed-latency memory wait counter; loads MEM_WAIT-1, counts down, done at zero.
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = MEM_WAIT > 1 ? $clog2(MEM_WAIT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge Clk)
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(MEM_WAIT - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);

    assign done = cnt == '0;

endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore fetch/decode/execute sequencer driving all LC-3 datapath controls.
// Define LC3_PAUSE_EN to enable the 1101 pause instruction (PauseIR1/PauseIR2 handshake on Continue).
module lc3_control_fsm
    import lc3_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [4:0] state_out
);

    logic [4:0] state, state_next;
    logic       wait_done, wait_load, wait_dec;
    ctrl_t      c;

`ifndef LC3_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    // Counter reloads only on entry, so back-to-back wait states would each get a fresh count.
    assign wait_load = is_wait_state(state_next) && state_next != state;
    assign wait_dec  = is_wait_state(state);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .Clk   (Clk),
        .reset (reset),
        .load  (wait_load),
        .dec   (wait_dec),
        .done  (wait_done)
    );

    always_ff @(posedge Clk)
        if (reset)
            state <= S_HALTED;
        else
            state <= state_next;

    always_comb begin
        state_next = S_18;
        case (state)
            S_HALTED: state_next = Run ? S_18 : S_HALTED;
            S_18:     state_next = S_33;
            S_33:     state_next = wait_done ? S_35 : S_33;
            S_35:     state_next = S_32;
            S_32:
                case (Opcode)
                    OP_ADD:   state_next = S_01;
                    OP_AND:   state_next = S_05;
                    OP_NOT:   state_next = S_09;
                    OP_BR:    state_next = S_00;
                    OP_JMP:   state_next = S_12;
                    OP_JSR:   state_next = S_04;
                    OP_LDR:   state_next = S_06;
                    OP_STR:   state_next = S_07;
`ifdef LC3_PAUSE_EN
                    OP_PAUSE: state_next = S_PAUSE1;
`endif
                    default:  state_next = S_18;
                endcase
            S_00:     state_next = BEN ? S_22 : S_18;
            S_04:     state_next = S_21;
            S_06:     state_next = S_25;
            S_25:     state_next = wait_done ? S_27 : S_25;
            S_07:     state_next = S_23;
            S_23:     state_next = S_16;
            S_16:     state_next = wait_done ? S_18 : S_16;
`ifdef LC3_PAUSE_EN
            S_PAUSE1: state_next = Continue ? S_PAUSE2 : S_PAUSE1;
            S_PAUSE2: state_next = Continue ? S_PAUSE2 : S_18;
`endif
            default:  state_next = S_18;
        endcase
    end

    // IR_5/IR_11 are IR bits, so steering them straight into the mux selects keeps this Moore.
    always_comb begin
        c = '0;
        case (state)
            S_18: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.pcmux   = PC_INC;
                c.ld_pc   = 1'b1;
            end
            S_33: begin
                c.mem_oe = 1'b1;
                c.ld_mdr = wait_done;
            end
            S_35: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
            end
            S_32: c.ld_ben = 1'b1;
            S_01, S_05, S_09: begin
                c.sr1mux   = 1'b1;
                c.sr2mux   = state == S_09 ? 1'b0 : IR_5;
                c.aluk     = state == S_01 ? ALU_ADD : state == S_05 ? ALU_AND : ALU_NOT;
                c.gate_alu = 1'b1;
                c.drmux    = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_22: begin
                c.addr1mux = 1'b0;
                c.addr2mux = A2_OFF9;
                c.pcmux    = PC_ADDR;
                c.ld_pc    = 1'b1;
            end
            S_12: begin
                c.sr1mux   = 1'b1;
                c.addr1mux = 1'b1;
                c.addr2mux = A2_ZERO;
                c.pcmux    = PC_ADDR;
                c.ld_pc    = 1'b1;
            end
            S_04: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b0;
                c.ld_reg  = 1'b1;
            end
            S_21: begin
                c.addr1mux = ~IR_11;
                c.sr1mux   = ~IR_11;
                c.addr2mux = IR_11 ? A2_OFF11 : A2_ZERO;
                c.pcmux    = PC_ADDR;
                c.ld_pc    = 1'b1;
            end
            S_06, S_07: begin
                c.sr1mux      = 1'b1;
                c.addr1mux    = 1'b1;
                c.addr2mux    = A2_OFF6;
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
            end
            S_25: begin
                c.mem_oe = 1'b1;
                c.ld_mdr = wait_done;
            end
            S_27: begin
                c.gate_mdr = 1'b1;
                c.drmux    = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
            end
            S_23: begin
                c.sr1mux   = 1'b0;
                c.aluk     = ALU_PASSA;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
            end
            S_16: c.mem_we = 1'b1;
`ifdef LC3_PAUSE_EN
            S_PAUSE1: c.ld_led = 1'b1;
`endif
            default: c = '0;
        endcase
    end

    assign {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
            GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
            ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE} = c;
    assign state_out = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: builds each instruction's expected per-cycle control trace and compares cycle by cycle.
// Honours LC3_PAUSE_EN the same way as the design.
module tb_lc3_control_fsm;
    import lc3_control_fsm_pkg::*;

    localparam int MW = 3;

    logic       Clk = 1'b0;
    logic       reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic [4:0] state_out;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic g_pc, g_mdr, g_alu, g_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic oe, we;
        logic [4:0] st;
    } cv_t;

    typedef struct {
        cv_t        e;
        logic       first, i5, i11, b, cont;
        logic [3:0] op;
        int         idx;
    } step_t;

    cv_t        dv;
    step_t      q[$];
    int         checks = 0, errors = 0, m_n;
    logic [3:0] m_op;
    logic       m_i5, m_i11, m_b;

    always #5 Clk = ~Clk;

    lc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .reset(reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .state_out(state_out)
    );

    assign dv = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                 GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                 ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, state_out};

    function automatic cv_t z(input logic [4:0] s);
        cv_t c;
        c = '0;
        c.st = s;
        return c;
    endfunction

    task automatic add(input cv_t c, input logic cont);
        step_t s;
        s.e = c; s.op = m_op; s.i5 = m_i5; s.i11 = m_i11; s.b = m_b; s.cont = cont;
        s.first = m_n == 0; s.idx = m_n;
        m_n++;
        q.push_back(s);
    endtask

    // Expected trace of one whole instruction, fetch included.
    task automatic gen(input logic [3:0] op, input logic i5, input logic i11, input logic b);
        cv_t c;
        m_op = op; m_i5 = i5; m_i11 = i11; m_b = b; m_n = 0;
        c = z(S_18); c.g_pc = 1; c.ld_mar = 1; c.ld_pc = 1; add(c, 1'($urandom));
        for (int i = 0; i < MW; i++) begin
            c = z(S_33); c.oe = 1; c.ld_mdr = i == MW - 1; add(c, 1'($urandom));
        end
        c = z(S_35); c.g_mdr = 1; c.ld_ir = 1; add(c, 1'($urandom));
        c = z(S_32); c.ld_ben = 1; add(c, 1'($urandom));
        if (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) begin
            c = z(op == 4'b0001 ? S_01 : op == 4'b0101 ? S_05 : S_09);
            c.sr1mux = 1; c.sr2mux = op == 4'b1001 ? 1'b0 : i5;
            c.aluk = op == 4'b0001 ? 2'd0 : op == 4'b0101 ? 2'd1 : 2'd2;
            c.g_alu = 1; c.drmux = 1; c.ld_reg = 1; c.ld_cc = 1; add(c, 1'($urandom));
        end else if (op == 4'b0000) begin
            add(z(S_00), 1'($urandom));
            if (b) begin
                c = z(S_22); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; add(c, 1'($urandom));
            end
        end else if (op == 4'b1100) begin
            c = z(S_12); c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; add(c, 1'($urandom));
        end else if (op == 4'b0100) begin
            c = z(S_04); c.g_pc = 1; c.ld_reg = 1; add(c, 1'($urandom));
            c = z(S_21); c.pcmux = 2'b10; c.ld_pc = 1;
            if (i11) c.addr2mux = 2'b11;
            else begin c.addr1mux = 1; c.sr1mux = 1; end
            add(c, 1'($urandom));
        end else if (op == 4'b0110 || op == 4'b0111) begin
            c = z(op == 4'b0110 ? S_06 : S_07);
            c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.g_marmux = 1; c.ld_mar = 1;
            add(c, 1'($urandom));
            if (op == 4'b0110) begin
                for (int i = 0; i < MW; i++) begin
                    c = z(S_25); c.oe = 1; c.ld_mdr = i == MW - 1; add(c, 1'($urandom));
                end
                c = z(S_27); c.g_mdr = 1; c.drmux = 1; c.ld_reg = 1; c.ld_cc = 1; add(c, 1'($urandom));
            end else begin
                c = z(S_23); c.aluk = 2'b11; c.g_alu = 1; c.ld_mdr = 1; add(c, 1'($urandom));
                for (int i = 0; i < MW; i++) begin
                    c = z(S_16); c.we = 1; add(c, 1'($urandom));
                end
            end
        end
`ifdef LC3_PAUSE_EN
        else if (op == 4'b1101) begin
            c = z(S_PAUSE1); c.ld_led = 1; add(c, 1'b0); add(c, 1'b1);
            c = z(S_PAUSE2); add(c, 1'b1); add(c, 1'b0);
        end
`endif
    endtask

    task automatic run_steps(input int n);
        step_t s;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            s = q.pop_front();
            if (s.first) begin
                Opcode = s.op; IR_5 = s.i5; IR_11 = s.i11; BEN = s.b;
            end
            checks++;
            assert (dv === s.e) else begin
                errors++;
                $error("FAIL op%b_step%0d: got %h expected %h", s.op, s.idx, dv, s.e);
            end
            checks++;
            assert ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) else begin
                errors++;
                $error("FAIL gate_single op%b_step%0d: got gates %b expected at most one", s.op, s.idx,
                       {GatePC, GateMDR, GateALU, GateMARMUX});
            end
            Continue = s.cont;
            Run = 1'($urandom);
            @(negedge Clk);
        end
    endtask

    task automatic chk_idle(input string tag);
        checks++;
        assert (dv === z(S_HALTED)) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, dv, z(S_HALTED));
        end
    endtask

    task automatic start;
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    task automatic mid_reset(input logic [3:0] op, input int n);
        gen(op, 1'b0, 1'b0, 1'b0);
        run_steps(n);
        q.delete();
        reset = 1'b1; Run = 1'b0;
        @(negedge Clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        @(negedge Clk);
        chk_idle("post_reset_idle");
        start();
    endtask

    initial begin
        reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = '0; IR_5 = 0; IR_11 = 0; BEN = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_idle("reset");
        reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk_idle("halted_no_run");
        end
        start();
        gen(4'b0001, 1, 0, 0); gen(4'b0000, 0, 0, 0); gen(4'b0000, 0, 0, 1);
        gen(4'b0110, 0, 0, 0); gen(4'b0111, 0, 0, 0); gen(4'b1101, 0, 0, 0);
        gen(4'b0100, 0, 1, 0); gen(4'b0100, 0, 0, 0); gen(4'b1100, 0, 0, 0);
        gen(4'b1001, 0, 0, 0); gen(4'b0101, 0, 0, 0); gen(4'b1111, 0, 0, 0);
        run_steps(100000);
        repeat (40) gen(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        run_steps(100000);
        mid_reset(4'b0110, 2);
        mid_reset(4'b0111, MW + 5);
        repeat (10) gen(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        run_steps(100000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
